// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: rebuilds pixel_x/pixel_y/video_on from hsync/vsync/p_tick
// with a flywheel counter, checks sync edge placement and tracks lock.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   p_tick                 pixel enable; all state advances only on p_tick
//   hsync_in, vsync_in     active-high syncs from the generator
//   pixel_x, pixel_y       recovered position (registered)
//   video_on               locked and inside the visible area
//   line_start             one-clk pulse on flywheel wrap of x to 0
//   frame_start            one-clk pulse on flywheel wrap of x and y to 0
//   locked                 lock status
//   h_err, v_err           one-clk pulses on misplaced or missing sync edges
//   err_count              saturating count of error pulses
//   meas_htotal            p_ticks between the last two hsync rises
//
// Build option: define VGA_RX_STATS_EN to make err_count and meas_htotal live;
// otherwise both are tied to zero and no statistics logic is built.

module vga_sync_receiver #(
    parameter int HD          = 640,
    parameter int HTOTAL      = 800,
    parameter int HSYNC_X     = 656,
    parameter int VD          = 480,
    parameter int VTOTAL      = 616,
    parameter int VSYNC_Y     = 513,
    parameter int LOCK_FRAMES = 2,
    parameter int MISS_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] err_count,
    output logic [9:0]  meas_htotal
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [9:0] X_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0] X_SYNC = 10'(HSYNC_X);
    localparam logic [9:0] X_CHK  = 10'(HSYNC_X + 1);
    localparam logic [9:0] Y_SYNC = 10'(VSYNC_Y);
    localparam logic [9:0] X_VIS  = 10'(HD);
    localparam logic [9:0] Y_VIS  = 10'(VD);
    localparam logic [3:0] GOOD_MAX = 4'(LOCK_FRAMES);
    localparam logic [3:0] BAD_MAX  = 4'(MISS_LIMIT);

    // Sync levels at the previous p_tick sample, for rise detection.
    logic       hs_q;
    logic       vs_q;
    // Per-line / per-frame bookkeeping for the missing-edge checks.
    logic       h_seen;
    logic       v_seen;
    // At least one hsync rise seen since entering SEARCH.
    logic       h_any;
    logic       frame_bad;
    logic [1:0] state;
    logic [3:0] good_cnt;
    logic [3:0] bad_cnt;

    logic       h_rise;
    logic       v_rise;
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] fly_x;
    logic [9:0] fly_y;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       checking;
    logic       h_err_c;
    logic       v_err_c;
    logic       line_wrap;
    logic       frame_wrap;
    logic       bad_now;

    logic [1:0] state_nx;
    logic [3:0] good_nx;
    logic [3:0] bad_nx;
    logic       h_any_nx;
    logic       fbad_nx;
    logic       lock_nx;

    assign h_rise = p_tick & hsync_in & ~hs_q;
    assign v_rise = p_tick & vsync_in & ~vs_q;

    assign x_wrap = (pixel_x == X_LAST);
    assign y_wrap = (pixel_y == Y_LAST);

    always_comb begin
        fly_x = x_wrap ? 10'd0 : pixel_x + 10'd1;
        fly_y = pixel_y;
        if (x_wrap) begin
            fly_y = y_wrap ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Sync loads take priority over the flywheel.
    assign nx = h_rise ? X_SYNC : fly_x;
    assign ny = v_rise ? Y_SYNC : fly_y;

    assign checking = (state != S_SEARCH);

    // Early/late hsync, or the line ran past the sync point without one.
    assign h_err_c = p_tick && checking &&
                     ((h_rise && (fly_x != X_SYNC)) ||
                      (!h_rise && !h_seen && (fly_x == X_CHK)));

    // Early/late vsync, or the sync line reached the hsync point without one.
    assign v_err_c = p_tick && checking &&
                     ((v_rise && (fly_y != Y_SYNC)) ||
                      (!v_rise && !v_seen &&
                       (nx == X_SYNC) && (fly_y == Y_SYNC)));

    // Wraps only count when the flywheel, not a load, produced them.
    assign line_wrap  = p_tick && x_wrap && !h_rise;
    assign frame_wrap = line_wrap && y_wrap && !v_rise;

    assign bad_now = frame_bad | h_err_c | v_err_c;

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        bad_nx   = bad_cnt;
        h_any_nx = h_any | h_rise;
        fbad_nx  = frame_wrap ? 1'b0 : bad_now;
        unique case (1'b1)
            (state == S_SEARCH): begin
                if (v_rise && h_any) begin
                    state_nx = S_ACQUIRE;
                    good_nx  = '0;
                    fbad_nx  = 1'b0;
                end
            end
            (state == S_ACQUIRE): begin
                if (frame_wrap) begin
                    if (bad_now) begin
                        good_nx = '0;
                    end else if (good_cnt + 4'd1 == GOOD_MAX) begin
                        state_nx = S_LOCKED;
                        good_nx  = '0;
                        bad_nx   = '0;
                    end else begin
                        good_nx = good_cnt + 4'd1;
                    end
                end
            end
            default: begin
                if (frame_wrap) begin
                    if (!bad_now) begin
                        bad_nx = '0;
                    end else if (bad_cnt + 4'd1 == BAD_MAX) begin
                        state_nx = S_SEARCH;
                        good_nx  = '0;
                        bad_nx   = '0;
                        h_any_nx = 1'b0;
                    end else begin
                        bad_nx = bad_cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    assign lock_nx = (state_nx == S_LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            h_any       <= 1'b0;
            frame_bad   <= 1'b0;
            state       <= S_SEARCH;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            // Pulse terms are already qualified by p_tick.
            h_err       <= h_err_c;
            v_err       <= v_err_c;
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
            if (p_tick) begin
                pixel_x   <= nx;
                pixel_y   <= ny;
                hs_q      <= hsync_in;
                vs_q      <= vsync_in;
                h_seen    <= h_rise | (h_seen & ~x_wrap);
                v_seen    <= v_rise | (v_seen & ~frame_wrap);
                h_any     <= h_any_nx;
                frame_bad <= fbad_nx;
                state     <= state_nx;
                good_cnt  <= good_nx;
                bad_cnt   <= bad_nx;
                locked    <= lock_nx;
                video_on  <= lock_nx && (nx < X_VIS) && (ny < Y_VIS);
            end
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [9:0]  gap_cnt;
    logic        h_first;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_count}
                   + {16'd0, h_err_c}
                   + {16'd0, v_err_c};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count   <= '0;
            meas_htotal <= '0;
            gap_cnt     <= '0;
            h_first     <= 1'b0;
        end else begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (p_tick) begin
                if (h_rise) begin
                    // gap_cnt holds distance-1 at the rise sample.
                    if (h_first) begin
                        meas_htotal <= (gap_cnt == 10'h3FF) ?
                                       gap_cnt : gap_cnt + 10'd1;
                    end
                    h_first <= 1'b1;
                    gap_cnt <= '0;
                end else if (gap_cnt != 10'h3FF) begin
                    gap_cnt <= gap_cnt + 10'd1;
                end
            end
        end
    end
`else
    assign err_count   = '0;
    assign meas_htotal = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: model generator drives scaled-down timing,
// a queue of generator positions is compared against the recovered outputs.
`timescale 1ns/1ps

module tb_vga_sync_receiver;

    localparam int HD  = 16;
    localparam int HT  = 24;
    localparam int HSX = 18;
    localparam int HSW = 3;
    localparam int VD  = 8;
    localparam int VT  = 12;
    localparam int VSY = 9;
    localparam int VSW = 2;
`ifdef VGA_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p_tick = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic [15:0] err_count;
    logic [9:0]  meas_htotal;

    vga_sync_receiver #(
        .HD(HD), .HTOTAL(HT), .HSYNC_X(HSX),
        .VD(VD), .VTOTAL(VT), .VSYNC_Y(VSY),
        .LOCK_FRAMES(2), .MISS_LIMIT(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .line_start(line_start),
        .frame_start(frame_start), .locked(locked),
        .h_err(h_err), .v_err(v_err),
        .err_count(err_count), .meas_htotal(meas_htotal)
    );

    always #10 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int f;
    } pos_t;

    pos_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   gx = 0;
    int   gy = 0;
    int   gframe = 0;
    bit   vs_off = 0;
    bit   early_arm = 0;

    function automatic logic vis(pos_t p);
        return (p.x < HD) && (p.y < VD);
    endfunction

    function automatic logic [21:0] pos_want(pos_t p);
        return {10'(p.x), 10'(p.y), p.x == 0, (p.x == 0) && (p.y == 0)};
    endfunction

    // One generator pixel: p_tick high for one clk, then one idle clk.
    // Returns at the negedge where the registered outputs of that sample show.
    task automatic step();
        @(negedge clk);
        p_tick   = 1'b1;
        hsync_in = (gx >= HSX) && (gx < HSX + HSW);
        vsync_in = !vs_off && (gy >= VSY) && (gy < VSY + VSW);
        exp_q.push_back('{gx, gy, gframe});
        gx++;
        if (early_arm && gx == HSX - 4) begin
            gx = HSX;
            early_arm = 0;
        end
        if (gx == HT) begin
            gx = 0;
            gy++;
            if (gy == VT) begin
                gy = 0;
                gframe++;
            end
        end
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({pixel_x, pixel_y, video_on, line_start, frame_start, locked,
             h_err, v_err, err_count, meas_htotal} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: x=%0d y=%0d lk=%b vo=%b ec=%0d mh=%0d want all 0",
                     pixel_x, pixel_y, locked, video_on, err_count, meas_htotal);
        end
        reset_n = 1'b1;
        gx = 0;
        gy = 0;
        gframe = 0;
    endtask

    task automatic test_lock();
        pos_t e;
        logic lk;
        while (!(gframe == 3 && gx == 0 && gy == 0)) begin
            step();
            e = exp_q.pop_front();
            lk = (e.f >= 2);
            n_chk++;
            if ({locked, video_on, h_err, v_err} !== {lk, lk & vis(e), 2'b00}) begin
                n_fail++;
                $display("FAIL lock_acq f=%0d x=%0d y=%0d: lk/vo/he/ve=%b%b%b%b want %b%b00",
                         e.f, e.x, e.y, locked, video_on, h_err, v_err, lk, lk & vis(e));
            end
            if (lk) begin
                n_chk++;
                if ({pixel_x, pixel_y, line_start, frame_start} !== pos_want(e)) begin
                    n_fail++;
                    $display("FAIL lock_pos: x=%0d y=%0d ls=%b fs=%b want x=%0d y=%0d",
                             pixel_x, pixel_y, line_start, frame_start, e.x, e.y);
                end
            end
        end
        n_chk++;
        if ({err_count, meas_htotal} !== {16'd0, 10'(STATS ? HT : 0)}) begin
            n_fail++;
            $display("FAIL lock_stats: ec=%0d mh=%0d want ec=0 mh=%0d",
                     err_count, meas_htotal, STATS ? HT : 0);
        end
    endtask

    task automatic test_early_hsync();
        pos_t e;
        int   f0;
        logic he;
        while (!(gx == 0 && gy == 2)) begin
            step();
            e = exp_q.pop_front();
        end
        f0 = gframe;
        early_arm = 1;
        while (!(gframe == f0 + 2 && gx == 0 && gy == 0)) begin
            step();
            e = exp_q.pop_front();
            he = (e.f == f0) && (e.y == 2) && (e.x == HSX);
            n_chk++;
            if ({locked, video_on, h_err, v_err} !== {1'b1, vis(e), he, 1'b0}) begin
                n_fail++;
                $display("FAIL early_h f=%0d x=%0d y=%0d: lk/vo/he/ve=%b%b%b%b want 1%b%b0",
                         e.f, e.x, e.y, locked, video_on, h_err, v_err, vis(e), he);
            end
            n_chk++;
            if ({pixel_x, pixel_y, line_start, frame_start} !== pos_want(e)) begin
                n_fail++;
                $display("FAIL early_pos: x=%0d y=%0d want x=%0d y=%0d",
                         pixel_x, pixel_y, e.x, e.y);
            end
            if (he) begin
                n_chk++;
                if ({err_count, meas_htotal} !==
                    {16'(STATS), 10'(STATS ? HT - 4 : 0)}) begin
                    n_fail++;
                    $display("FAIL early_stats: ec=%0d mh=%0d want ec=%0d mh=%0d",
                             err_count, meas_htotal, STATS, STATS ? HT - 4 : 0);
                end
            end
            if (e.f == f0 && e.y == 3 && e.x == HSX) begin
                n_chk++;
                if (meas_htotal !== 10'(STATS ? HT : 0)) begin
                    n_fail++;
                    $display("FAIL meas_next: mh=%0d want %0d",
                             meas_htotal, STATS ? HT : 0);
                end
            end
        end
    endtask

    task automatic test_vsync_loss();
        pos_t e;
        int   base;
        int   rel;
        logic lk;
        logic ve;
        base = gframe;
        while (!(gframe == base + 6 && gx == 0 && gy == 0)) begin
            vs_off = (gframe < base + 3);
            step();
            e = exp_q.pop_front();
            rel = e.f - base;
            lk = (rel < 3) || (rel >= 5);
            ve = (rel < 3) && (e.x == HSX) && (e.y == VSY);
            n_chk++;
            if ({locked, video_on, h_err, v_err} !== {lk, lk & vis(e), 1'b0, ve}) begin
                n_fail++;
                $display("FAIL vs_loss rel=%0d x=%0d y=%0d: lk/vo/he/ve=%b%b%b%b want %b%b0%b",
                         rel, e.x, e.y, locked, video_on, h_err, v_err,
                         lk, lk & vis(e), ve);
            end
            if (lk) begin
                n_chk++;
                if ({pixel_x, pixel_y, line_start, frame_start} !== pos_want(e)) begin
                    n_fail++;
                    $display("FAIL vs_loss_pos: x=%0d y=%0d want x=%0d y=%0d",
                             pixel_x, pixel_y, e.x, e.y);
                end
            end
        end
        vs_off = 0;
        n_chk++;
        if (err_count !== 16'(STATS ? 4 : 0)) begin
            n_fail++;
            $display("FAIL vs_loss_count: ec=%0d want %0d", err_count, STATS ? 4 : 0);
        end
    endtask

    task automatic test_freeze();
        pos_t e;
        e = '{0, 0, 0};
        while (!(e.x == 5 && e.y == 3)) begin
            step();
            e = exp_q.pop_front();
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_chk++;
            if ({pixel_x, pixel_y, video_on, locked, line_start, frame_start,
                 h_err, v_err} !== {10'd5, 10'd3, 6'b110000}) begin
                n_fail++;
                $display("FAIL freeze clk=%0d: x=%0d y=%0d vo=%b lk=%b want x=5 y=3 vo=1 lk=1",
                         i, pixel_x, pixel_y, video_on, locked);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            e = exp_q.pop_front();
            n_chk++;
            if ({pixel_x, pixel_y, locked, h_err, v_err} !==
                {10'(e.x), 10'(e.y), 3'b100}) begin
                n_fail++;
                $display("FAIL resume: x=%0d y=%0d lk=%b want x=%0d y=%0d lk=1",
                         pixel_x, pixel_y, locked, e.x, e.y);
            end
        end
    endtask

    task automatic test_mid_reset();
        pos_t e;
        int   base;
        logic lk;
        e = '{0, 0, 0};
        while (!(e.x == 10 && e.y == 5)) begin
            step();
            e = exp_q.pop_front();
        end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({pixel_x, pixel_y, video_on, line_start, frame_start, locked,
             h_err, v_err, err_count, meas_htotal} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: x=%0d y=%0d lk=%b vo=%b ec=%0d mh=%0d want all 0",
                     pixel_x, pixel_y, locked, video_on, err_count, meas_htotal);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = gframe;
        while (!(gframe == base + 3 && gx == 0 && gy == 0)) begin
            step();
            e = exp_q.pop_front();
            lk = (e.f >= base + 2);
            n_chk++;
            if ({locked, video_on, h_err, v_err} !== {lk, lk & vis(e), 2'b00}) begin
                n_fail++;
                $display("FAIL post_reset f=%0d x=%0d y=%0d: lk/vo/he/ve=%b%b%b%b want %b%b00",
                         e.f - base, e.x, e.y, locked, video_on, h_err, v_err,
                         lk, lk & vis(e));
            end
            if (lk) begin
                n_chk++;
                if ({pixel_x, pixel_y, line_start, frame_start} !== pos_want(e)) begin
                    n_fail++;
                    $display("FAIL post_reset_pos: x=%0d y=%0d want x=%0d y=%0d",
                             pixel_x, pixel_y, e.x, e.y);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_early_hsync();
        test_vsync_loss();
        test_freeze();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
